// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared types and constants for the divider sequencer
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } divctrl_state_t;

    localparam int DIV_LATENCY = 66;

    function automatic logic op_is_signed(input div_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_div(input div_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/divider_multicycle_from_single.sv
// rtl/divider_multicycle_from_single.sv - unsigned restoring divider, one quotient bit per cycle
// The first bit is produced on the load edge, so done follows the start pulse by WIDTH-1 edges.
module divider_multicycle_from_single #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] den_q, den_d;

    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] rem,
        input logic [WIDTH-1:0] quot,
        input logic [WIDTH-1:0] den
    );
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] trial;
        logic           ge;
        shifted = {rem, quot[WIDTH-1]};
        trial   = shifted - {1'b0, den};
        ge      = shifted >= {1'b0, den};
        return {(ge ? WIDTH'(trial) : WIDTH'(shifted)), quot[WIDTH-2:0], ge};
    endfunction

    always_comb begin
        busy_d = busy_q;
        done_d = 1'b0;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quot_d = quot_q;
        den_d  = den_q;
        if (valid) begin
            busy_d          = 1'b1;
            cnt_d           = CW'(1);
            den_d           = b;
            {rem_d, quot_d} = div_step('0, a, b);
        end else if (busy_q) begin
            cnt_d           = cnt_q + CW'(1);
            {rem_d, quot_d} = div_step(rem_q, quot_q, den_q);
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quot_q <= '0;
            den_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quot_q <= quot_d;
            den_q  <= den_d;
        end
    end

    assign done   = done_q;
    assign result = {rem_q, quot_q};

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - RV64M divide/remainder sequencer around the shared multicycle divider
// Signed and word ops are folded onto the unsigned core by magnitude prep and sign fix-up.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int FAST_SPEC = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  div_op_t         req_op,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data
);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_BUSY = 2'(BUSY);
    localparam logic [1:0] ST_RESP = 2'(RESP);
    localparam bit         FAST    = (FAST_SPEC != 0);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        return {{(XLEN-32){x[31]}}, x};
    endfunction

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
        return ~x + XLEN'(1);
    endfunction

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x, input logic sgn);
        return sgn ? negate(x) : x;
    endfunction

    logic [1:0]      state_q, state_d;
    logic            is_div_q, is_div_d;
    logic            word_q, word_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic [XLEN-1:0] core_a_q, core_a_d;
    logic [XLEN-1:0] core_b_q, core_b_d;
    logic            core_start_q, core_start_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;

    logic              accept;
    logic              is_signed;
    logic [XLEN-1:0]   a_ext, b_ext;
    logic              sa, sb;
    logic              b_zero, ovf, special;
    logic [XLEN-1:0]   most_neg;
    logic [XLEN-1:0]   spec_sel;
    logic [XLEN-1:0]   spec_res;
    logic              core_reset;
    logic              core_done;
    logic [2*XLEN-1:0] core_result;
    logic [XLEN-1:0]   quot, rem, post_sel, post_res;

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_data  = resp_data_q;
    assign accept     = req_valid & req_ready & ~flush;
    assign core_reset = reset | flush;

    // Operand extension and special-case detection on the incoming request
    always_comb begin
        is_signed = op_is_signed(req_op);
        if (req_word) begin
            a_ext = is_signed ? sext32(req_a[31:0]) : {{(XLEN-32){1'b0}}, req_a[31:0]};
            b_ext = is_signed ? sext32(req_b[31:0]) : {{(XLEN-32){1'b0}}, req_b[31:0]};
        end else begin
            a_ext = req_a;
            b_ext = req_b;
        end
        most_neg = req_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        sa       = is_signed & a_ext[XLEN-1];
        sb       = is_signed & b_ext[XLEN-1];
        b_zero   = (b_ext == '0);
        ovf      = is_signed & (a_ext == most_neg) & (b_ext == '1);
        special  = FAST & (b_zero | ovf);
        if (op_is_div(req_op)) spec_sel = b_zero ? '1 : a_ext;
        else                   spec_sel = b_zero ? a_ext : '0;
        spec_res = req_word ? sext32(spec_sel[31:0]) : spec_sel;
    end

    always_comb begin
        quot     = core_result[XLEN-1:0];
        rem      = core_result[2*XLEN-1:XLEN];
        post_sel = is_div_q ? (negq_q ? negate(quot) : quot)
                            : (negr_q ? negate(rem) : rem);
        post_res = word_q ? sext32(post_sel[31:0]) : post_sel;
    end

    always_comb begin
        state_d      = state_q;
        is_div_d     = is_div_q;
        word_d       = word_q;
        negq_d       = negq_q;
        negr_d       = negr_q;
        core_a_d     = core_a_q;
        core_b_d     = core_b_q;
        core_start_d = 1'b0;
        resp_data_d  = resp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    is_div_d = op_is_div(req_op);
                    word_d   = req_word;
                    negq_d   = (sa ^ sb) & ~b_zero;
                    negr_d   = sa;
                    core_a_d = abs_val(a_ext, sa);
                    core_b_d = abs_val(b_ext, sb);
                    if (special) begin
                        resp_data_d = spec_res;
                        state_d     = ST_RESP;
                    end else begin
                        core_start_d = 1'b1;
                        state_d      = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // done during the start-pulse cycle belongs to no operation of ours
                if (core_done && !core_start_q) begin
                    resp_data_d = post_res;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d      = ST_IDLE;
            core_start_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            is_div_q     <= 1'b0;
            word_q       <= 1'b0;
            negq_q       <= 1'b0;
            negr_q       <= 1'b0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            core_start_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            is_div_q     <= is_div_d;
            word_q       <= word_d;
            negq_q       <= negq_d;
            negr_q       <= negr_d;
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
            core_start_q <= core_start_d;
            resp_data_q  <= resp_data_d;
        end
    end

    divider_multicycle_from_single #(
        .WIDTH(XLEN)
    ) u_core (
        .clk   (clk),
        .reset (core_reset),
        .valid (core_start_q),
        .a     (core_a_q),
        .b     (core_b_q),
        .done  (core_done),
        .result(core_result)
    );

endmodule
